mem_access_unit: RTL and testbench

- MEM-stage controller that consumes the EX/MEM pipeline register outputs and performs loads and stores on a multi-cycle data-memory bus using a req/ack handshake.
- Drives the MEM/WB register inputs.
- Raises `stall`, which the hazard logic uses to deassert `write` on PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs loads and stores on a req/ack data bus, stalls the
// upstream pipeline while an access is outstanding, and flags misalignment and timeouts.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [ADDR_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        Dest_Reg_Addr_in,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [ADDR_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [4:0]        Dest_Reg_Addr_out,
    output logic              stall,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic mem_op;
    logic misaligned;
    logic start;
    logic expired;

    assign MemtoReg_out      = MemtoReg_in;
    assign ALU_result_out    = ALU_result_in;
    assign Dest_Reg_Addr_out = Dest_Reg_Addr_in;

    always_comb begin
        mem_op     = MemRead_in | MemWrite_in;
        misaligned = mem_op & (ALU_result_in[1:0] != 2'b00);
        start      = (state == IDLE) & mem_op & ~misaligned;
        expired    = (count == LAST_COUNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack || expired) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bus request and address/data are captured once at launch and held until the
    // access resolves, so the bus sees stable values for the whole handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in;
                        mem_addr  <= ALU_result_in;
                        mem_wdata <= store_data_in;
                        count     <= '0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_we ? '0 : mem_rdata;
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // A launching access sends a bubble to MEM/WB; the real writeback happens in DONE.
    always_comb begin
        stall         = 1'b0;
        RegWrite_out  = 1'b0;
        read_data_out = '0;
        mem_err       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    stall        = start;
                    mem_err      = misaligned;
                    RegWrite_out = RegWrite_in & ~mem_op;
                end
                ACCESS: begin
                    stall = 1'b1;
                end
                DONE: begin
                    read_data_out = rdata_q;
                    RegWrite_out  = RegWrite_in & ~err_q;
                    mem_err       = err_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios then randomized
// instructions, each predicted at transaction level (stall length, bus fields, result).
module tb_mem_access_unit;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic              clock;
    logic              reset;
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic              MemRead_in;
    logic              MemWrite_in;
    logic [ADDR_W-1:0] ALU_result_in;
    logic [DATA_W-1:0] store_data_in;
    logic [4:0]        Dest_Reg_Addr_in;
    logic              RegWrite_out;
    logic              MemtoReg_out;
    logic [ADDR_W-1:0] ALU_result_out;
    logic [DATA_W-1:0] read_data_out;
    logic [4:0]        Dest_Reg_Addr_out;
    logic              stall;
    logic              mem_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int errorCount = 0;
    int checkCount = 0;

    mem_access_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .RegWrite_in      (RegWrite_in),
        .MemtoReg_in      (MemtoReg_in),
        .MemRead_in       (MemRead_in),
        .MemWrite_in      (MemWrite_in),
        .ALU_result_in    (ALU_result_in),
        .store_data_in    (store_data_in),
        .Dest_Reg_Addr_in (Dest_Reg_Addr_in),
        .RegWrite_out     (RegWrite_out),
        .MemtoReg_out     (MemtoReg_out),
        .ALU_result_out   (ALU_result_out),
        .read_data_out    (read_data_out),
        .Dest_Reg_Addr_out(Dest_Reg_Addr_out),
        .stall            (stall),
        .mem_err          (mem_err),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic rw, input logic m2r,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
        MemRead_in       = rd;
        MemWrite_in      = wr;
        RegWrite_in      = rw;
        MemtoReg_in      = m2r;
        ALU_result_in    = addr;
        store_data_in    = wdata;
        Dest_Reg_Addr_in = dest;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkPassThrough(input logic m2r, input logic [31:0] addr, input logic [4:0] dest);
        checkOutput("alu_pass", ALU_result_out, addr);
        checkOutput("dest_pass", 32'(Dest_Reg_Addr_out), 32'(dest));
        checkOutput("m2r_pass", 32'(MemtoReg_out), 32'(m2r));
    endtask

    // kind: 0 = no memory op, 1 = load, 2 = store, 3 = both (acts as store).
    // ackDelay >= TIMEOUT means the bus never answers.
    task automatic runOp(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ackDelay, input logic rw,
                         input logic m2r, input logic [4:0] dest, input logic strayAck);
        logic rd, wr, memOp, mis, timedOut;
        int   accessCycles, stallSeen;
        rd       = (kind == 1) || (kind == 3);
        wr       = (kind >= 2);
        memOp    = rd | wr;
        mis      = memOp && (addr[1:0] != 2'b00);
        timedOut = (ackDelay >= TIMEOUT);
        applyStimulus(rd, wr, rw, m2r, addr, wdata, dest);
        mem_ack   = strayAck;
        mem_rdata = $urandom;
        #1;
        checkPassThrough(m2r, addr, dest);
        checkOutput("mem_req_idle", 32'(mem_req), 32'd0);
        if (!memOp || mis) begin
            checkOutput("stall_single", 32'(stall), 32'd0);
            checkOutput("mem_err_single", 32'(mem_err), 32'(mis));
            checkOutput("regwrite_single", 32'(RegWrite_out), memOp ? 32'd0 : 32'(rw));
            checkOutput("rdata_single", read_data_out, 32'd0);
            nextCycle();
            mem_ack = 1'b0;
            return;
        end
        stallSeen = int'(stall);
        checkOutput("stall_launch", 32'(stall), 32'd1);
        checkOutput("regwrite_launch", 32'(RegWrite_out), 32'd0);
        checkOutput("mem_err_launch", 32'(mem_err), 32'd0);
        nextCycle();
        accessCycles = timedOut ? TIMEOUT : ackDelay + 1;
        for (int i = 0; i < accessCycles; i++) begin
            mem_ack   = !timedOut && (i == ackDelay);
            mem_rdata = mem_ack ? rdata : $urandom;
            #1;
            stallSeen += int'(stall);
            checkOutput("mem_req_access", 32'(mem_req), 32'd1);
            checkOutput("mem_we", 32'(mem_we), 32'(wr));
            checkOutput("mem_addr", mem_addr, addr);
            checkOutput("mem_wdata", mem_wdata, wdata);
            checkOutput("regwrite_access", 32'(RegWrite_out), 32'd0);
            checkOutput("mem_err_access", 32'(mem_err), 32'd0);
            nextCycle();
        end
        mem_ack   = strayAck;
        mem_rdata = $urandom;
        #1;
        stallSeen += int'(stall);
        checkOutput("stall_len", 32'(stallSeen), 32'(accessCycles + 1));
        checkOutput("mem_req_done", 32'(mem_req), 32'd0);
        checkOutput("rdata_done", read_data_out, (!timedOut && !wr) ? rdata : 32'd0);
        checkOutput("regwrite_done", 32'(RegWrite_out), 32'(rw & ~timedOut));
        checkOutput("mem_err_done", 32'(mem_err), 32'(timedOut));
        checkPassThrough(m2r, addr, dest);
        nextCycle();
        mem_ack = 1'b0;
    endtask

    initial begin
        int kind, delay;
        logic [31:0] addr;
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hAAAA_5555, 5'd7);
        nextCycle();
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_regwrite", 32'(RegWrite_out), 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("rst_rdata", read_data_out, 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        nextCycle();
        reset = 1'b0;

        runOp(0, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b1, 1'b0, 5'd5, 1'b0);
        runOp(1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b1, 5'd8, 1'b0);
        runOp(2, 32'h0000_0204, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 5'd0, 1'b0);
        runOp(1, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b1, 1'b1, 5'd9, 1'b0);
        runOp(1, 32'h0000_0400, 32'h0, 32'h0, TIMEOUT, 1'b1, 1'b1, 5'd10, 1'b0);
        runOp(0, 32'h0000_0041, 32'h0, 32'h0, 0, 1'b1, 1'b0, 5'd11, 1'b1);
        runOp(1, 32'h0000_0408, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 1'b1, 1'b1, 5'd12, 1'b0);
        runOp(3, 32'h0000_040C, 32'h0BAD_F00D, 32'h1111_2222, 1, 1'b1, 1'b0, 5'd13, 1'b1);

        // Reset lands in the second ACCESS cycle of a load and must discard it.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd14);
        #1;
        checkOutput("pre_rst_stall", 32'(stall), 32'd1);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_regwrite", 32'(RegWrite_out), 32'd0);
        checkOutput("midrst_rdata", read_data_out, 32'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        checkOutput("postrst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("postrst_stall", 32'(stall), 32'd0);
        nextCycle();
        runOp(1, 32'h0000_0300, 32'h0, 32'h5A5A_A5A5, 0, 1'b1, 1'b1, 5'd15, 1'b0);
        runOp(1, 32'h0000_0304, 32'h0, 32'h0F0F_F0F0, 2, 1'b1, 1'b1, 5'd16, 1'b0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            delay = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 5);
            runOp(kind, addr, $urandom, $urandom, delay, 1'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
